// File: rtl/cpu_sequencer.sv
// Fetch/decode/indirect/execute control sequencer for a single-accumulator style CPU.
// Memory and datapath use req/ack and start/done handshakes; every output is registered.
module cpu_sequencer #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12,
  parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  output logic              mem_req,
  output logic [AWIDTH-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              ex_start,
  output logic [2:0]        ex_op,
  output logic [AWIDTH-1:0] ex_reg,
  output logic [AWIDTH-1:0] ex_ea,
  input  logic              ex_done,
  input  logic              ex_skip,
  output logic [AWIDTH-1:0] pc,
  output logic [DWIDTH-1:0] ir,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    INDIRECT,
    EXECUTE,
    HALT
  } state_t;

  localparam logic [2:0] OP_BRANCH = 3'd4;
  localparam logic [2:0] OP_REGREF = 3'd7;

  state_t            state;
  logic              i_bit;
  logic [2:0]        opcode;
  logic [AWIDTH-1:0] addr_f;
  logic [AWIDTH-1:0] pc_inc;
  logic [AWIDTH-1:0] ind_ea;

  assign i_bit  = ir[DWIDTH-1];
  assign opcode = ir[DWIDTH-2:DWIDTH-4];
  assign addr_f = ir[AWIDTH-1:0];
  assign pc_inc = pc + AWIDTH'(1);
  assign ind_ea = mem_rdata[AWIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      ir       <= '0;
      ex_ea    <= '0;
      ex_reg   <= '0;
      ex_op    <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      ex_start <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
    end else begin
      ex_start <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state    <= FETCH;
            mem_req  <= 1'b1;
            mem_addr <= pc;
            busy     <= 1'b1;
          end
        end

        FETCH: begin
          if (mem_req && mem_ack) begin
            ir      <= mem_rdata;
            pc      <= pc_inc;
            mem_req <= 1'b0;
            state   <= DECODE;
          end
        end

        DECODE: begin
          ex_op <= opcode;
          if (opcode == OP_REGREF) begin
            // Illegal indirect reg-ref and HLT (bit 0) both stop the machine.
            if (i_bit || addr_f[0]) begin
              state  <= HALT;
              halted <= 1'b1;
              busy   <= 1'b0;
            end else begin
              ex_reg   <= addr_f;
              ex_start <= 1'b1;
              state    <= EXECUTE;
            end
          end else if (i_bit) begin
            mem_req  <= 1'b1;
            mem_addr <= addr_f;
            state    <= INDIRECT;
          end else begin
            ex_ea <= addr_f;
            if (opcode == OP_BRANCH) begin
              pc       <= addr_f;
              mem_req  <= 1'b1;
              mem_addr <= addr_f;
              state    <= FETCH;
            end else begin
              ex_start <= 1'b1;
              state    <= EXECUTE;
            end
          end
        end

        INDIRECT: begin
          if (mem_req && mem_ack) begin
            ex_ea <= ind_ea;
            if (opcode == OP_BRANCH) begin
              // Next fetch starts straight away, so the request stays up on the new address.
              pc       <= ind_ea;
              mem_addr <= ind_ea;
              state    <= FETCH;
            end else begin
              mem_req  <= 1'b0;
              ex_start <= 1'b1;
              state    <= EXECUTE;
            end
          end
        end

        EXECUTE: begin
          if (ex_done) begin
            pc       <= ex_skip ? pc_inc : pc;
            mem_addr <= ex_skip ? pc_inc : pc;
            mem_req  <= 1'b1;
            state    <= FETCH;
          end
        end

        HALT: begin
          state <= HALT;
        end

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: memory and datapath handshakes are driven step by step
// with hand-computed expectations.
module tb_cpu_sequencer;

  logic        clk;
  logic        reset_n;
  logic        run;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        ex_start;
  logic [2:0]  ex_op;
  logic [11:0] ex_reg;
  logic [11:0] ex_ea;
  logic        ex_done;
  logic        ex_skip;
  logic [11:0] pc;
  logic [15:0] ir;
  logic        busy;
  logic        halted;

  int tests;
  int fails;

  cpu_sequencer #(
    .DWIDTH(16),
    .AWIDTH(12),
    .RESET_PC(12'h000)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .run(run),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .ex_start(ex_start),
    .ex_op(ex_op),
    .ex_reg(ex_reg),
    .ex_ea(ex_ea),
    .ex_done(ex_done),
    .ex_skip(ex_skip),
    .pc(pc),
    .ir(ir),
    .busy(busy),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-cycle, check the asynchronous clear, release after one edge.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_pc", 32'(pc), 32'h000);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    tick();
    reset_n = 1'b1;
  endtask

  // Serve one memory read: request must already be up on addr and stay put through waits.
  task automatic do_mem(input string tag, input logic [11:0] addr, input logic [15:0] data,
                        input int waits);
    check({tag, "_req"}, 32'(mem_req), 32'h1);
    check({tag, "_addr"}, 32'(mem_addr), 32'(addr));
    for (int w = 0; w < waits; w++) begin
      tick();
      check({tag, "_req_hold"}, 32'(mem_req), 32'h1);
      check({tag, "_addr_hold"}, 32'(mem_addr), 32'(addr));
    end
    mem_ack   = 1'b1;
    mem_rdata = data;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    reset_n   = 1'b1;
    run       = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    ex_done   = 1'b0;
    ex_skip   = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("init_mem_req", 32'(mem_req), 32'h0);
    check("init_ex_start", 32'(ex_start), 32'h0);
    check("init_pc", 32'(pc), 32'h000);
    check("init_ir", 32'(ir), 32'h0000);
    check("init_ex_ea", 32'(ex_ea), 32'h000);
    check("init_ex_reg", 32'(ex_reg), 32'h000);
    check("init_ex_op", 32'(ex_op), 32'h0);
    check("init_busy", 32'(busy), 32'h0);
    check("init_halted", 32'(halted), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    check("idle_wait_req", 32'(mem_req), 32'h0);

    // Direct load with two wait states.
    run = 1'b1;
    tick();
    run = 1'b0;
    check("s1_busy", 32'(busy), 32'h1);
    do_mem("s1_fetch", 12'h000, 16'h2123, 2);
    check("s1_req_drop", 32'(mem_req), 32'h0);
    check("s1_ir", 32'(ir), 32'h2123);
    check("s1_pc", 32'(pc), 32'h001);
    check("s1_no_start_decode", 32'(ex_start), 32'h0);
    tick();
    check("s1_start", 32'(ex_start), 32'h1);
    check("s1_op", 32'(ex_op), 32'h2);
    check("s1_ea", 32'(ex_ea), 32'h123);
    tick();
    check("s1_start_pulse", 32'(ex_start), 32'h0);
    check("s1_op_hold", 32'(ex_op), 32'h2);
    check("s1_ea_hold", 32'(ex_ea), 32'h123);
    check("s1_busy_exec", 32'(busy), 32'h1);
    ex_done = 1'b1;
    tick();
    ex_done = 1'b0;
    check("s1_next_req", 32'(mem_req), 32'h1);
    check("s1_next_addr", 32'(mem_addr), 32'h001);

    // Indirect add, zero-wait acks, same-cycle done.
    do_reset();
    run = 1'b1;
    tick();
    run = 1'b0;
    do_mem("s2_fetch", 12'h000, 16'h9050, 0);
    check("s2_decode_req", 32'(mem_req), 32'h0);
    tick();
    do_mem("s2_ind", 12'h050, 16'h0ABC, 0);
    check("s2_start", 32'(ex_start), 32'h1);
    check("s2_op", 32'(ex_op), 32'h1);
    check("s2_ea", 32'(ex_ea), 32'hABC);
    check("s2_ir_kept", 32'(ir), 32'h9050);
    ex_done = 1'b1;
    tick();
    ex_done = 1'b0;
    check("s2_next_addr", 32'(mem_addr), 32'h001);
    check("s2_next_req", 32'(mem_req), 32'h1);

    // Direct then indirect branch.
    do_reset();
    run = 1'b1;
    tick();
    run = 1'b0;
    do_mem("s3_fetch", 12'h000, 16'h4200, 0);
    check("s3_decode_start", 32'(ex_start), 32'h0);
    tick();
    check("s3_br_start", 32'(ex_start), 32'h0);
    check("s3_br_pc", 32'(pc), 32'h200);
    do_mem("s3_fetch2", 12'h200, 16'hC010, 0);
    tick();
    do_mem("s3_ind", 12'h010, 16'h0300, 0);
    check("s3_ibr_start", 32'(ex_start), 32'h0);
    check("s3_ibr_pc", 32'(pc), 32'h300);
    check("s3_ibr_req", 32'(mem_req), 32'h1);
    check("s3_ibr_addr", 32'(mem_addr), 32'h300);

    // Skip, PC wrap, ex_done ignored outside EXECUTE.
    do_reset();
    run = 1'b1;
    tick();
    run = 1'b0;
    do_mem("s4_fetch", 12'h000, 16'h6040, 0);
    tick();
    check("s4_start", 32'(ex_start), 32'h1);
    check("s4_op", 32'(ex_op), 32'h6);
    check("s4_ea", 32'(ex_ea), 32'h040);
    ex_done = 1'b1;
    ex_skip = 1'b1;
    tick();
    ex_done = 1'b0;
    ex_skip = 1'b0;
    check("s4_skip_pc", 32'(pc), 32'h002);
    do_mem("s4_fetch_skip", 12'h002, 16'h4FFF, 0);
    tick();
    do_mem("s4_fetch_top", 12'hFFF, 16'h7002, 0);
    check("s4_wrap_pc", 32'(pc), 32'h000);
    tick();
    check("s4_rr_start", 32'(ex_start), 32'h1);
    check("s4_rr_op", 32'(ex_op), 32'h7);
    check("s4_rr_reg", 32'(ex_reg), 32'h002);
    ex_done = 1'b1;
    tick();
    ex_skip = 1'b1;
    tick();
    tick();
    ex_done = 1'b0;
    ex_skip = 1'b0;
    check("s4_stray_done_pc", 32'(pc), 32'h000);
    do_mem("s4_fetch_wrap", 12'h000, 16'h0000, 0);

    // HLT and illegal indirect register reference.
    do_reset();
    run = 1'b1;
    tick();
    run = 1'b0;
    do_mem("s5_fetch", 12'h000, 16'h7001, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      run = i[0];
      tick();
      check("s5_halted", 32'(halted), 32'h1);
      check("s5_busy", 32'(busy), 32'h0);
      check("s5_start", 32'(ex_start), 32'h0);
      check("s5_req", 32'(mem_req), 32'h0);
    end
    run = 1'b0;
    do_reset();
    run = 1'b1;
    tick();
    run = 1'b0;
    do_mem("s5_fetch_ill", 12'h000, 16'hF000, 0);
    tick();
    check("s5_ill_halted", 32'(halted), 32'h1);
    check("s5_ill_start", 32'(ex_start), 32'h0);

    // Reset during a pending fetch, then a late ack.
    do_reset();
    run = 1'b1;
    tick();
    run = 1'b0;
    do_mem("s6_fetch", 12'h000, 16'h4345, 0);
    tick();
    check("s6_pend_addr", 32'(mem_addr), 32'h345);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("s6_abort_req", 32'(mem_req), 32'h0);
    check("s6_abort_pc", 32'(pc), 32'h000);
    check("s6_abort_busy", 32'(busy), 32'h0);
    check("s6_abort_ir", 32'(ir), 32'h0000);
    mem_ack   = 1'b1;
    mem_rdata = 16'h7001;
    tick();
    reset_n = 1'b1;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    check("s6_late_req", 32'(mem_req), 32'h0);
    check("s6_late_ir", 32'(ir), 32'h0000);
    check("s6_late_halted", 32'(halted), 32'h0);
    check("s6_late_busy", 32'(busy), 32'h0);
    run = 1'b1;
    tick();
    run = 1'b0;
    check("s6_restart_req", 32'(mem_req), 32'h1);
    check("s6_restart_addr", 32'(mem_addr), 32'h000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter DWIDTH, default 16, instruction/memory data width; SHALL be >= AWIDTH+4.
REQ-002 Parameter AWIDTH, default 12, address width.
REQ-003 Parameter RESET_PC, default 0, PC value after reset.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 run  input  1  start request, sampled in IDLE.
REQ-007 mem_req  output  1  memory read request.
REQ-008 mem_addr  output  AWIDTH  request address, stable while mem_req=1.
REQ-009 mem_ack  input  1  memory completion; mem_rdata valid the same cycle.
REQ-010 mem_rdata  input  DWIDTH  read data.
REQ-011 ex_start  output  1  one-cycle pulse launching the datapath operation.
REQ-012 ex_op  output  3  opcode; ex_reg output  AWIDTH  register-reference micro-op field; ex_ea output  AWIDTH  effective address.
REQ-013 ex_done  input  1  datapath completion; ex_skip input  1  skip request, valid with ex_done.
REQ-014 pc  output  AWIDTH; ir  output  DWIDTH; busy  output  1; halted  output  1.

Function
REQ-015 Instruction format SHALL be: I=ir[DWIDTH-1]; opcode=ir[DWIDTH-2:DWIDTH-4]; address=ir[AWIDTH-1:0]; any remaining bits ignored.
REQ-016 States SHALL be IDLE, FETCH, DECODE, INDIRECT, EXECUTE, HALT.
REQ-017 IDLE: run=1 -> FETCH next cycle; otherwise stay; busy=0 only in IDLE and HALT.
REQ-018 FETCH: mem_req=1, mem_addr=pc; on mem_ack: ir<=mem_rdata, pc<=pc+1 modulo 2^AWIDTH, -> DECODE.
REQ-019 mem_req SHALL be asserted from the first FETCH/INDIRECT cycle, held with constant mem_addr until mem_ack, and deasserted the cycle after the ack; an ack in the same cycle as the first req cycle SHALL complete the access; mem_ack while mem_req=0 SHALL be ignored.
REQ-020 DECODE (one cycle): opcode=7, I=0 -> register-reference: ex_reg<=address field, -> EXECUTE; if address field bit 0=1 (HLT) -> HALT instead, no ex_start.
REQ-021 DECODE: opcode=7, I=1 -> illegal -> HALT.
REQ-022 DECODE: opcode 0-6, I=1 -> INDIRECT; I=0 -> ex_ea<=address field, then opcode 4 (BRANCH) -> pc<=ex_ea, -> FETCH (no ex_start); other opcodes -> EXECUTE.
REQ-023 INDIRECT: mem_req=1, mem_addr=address field; on mem_ack: ex_ea<=mem_rdata[AWIDTH-1:0]; opcode 4 -> pc<=that value, -> FETCH; else -> EXECUTE.
REQ-024 EXECUTE: ex_start=1 for exactly the first cycle in the state; ex_op, ex_reg, ex_ea held constant for the whole state; wait for ex_done.
REQ-025 ex_done sampled from the ex_start cycle onward (same-cycle done allowed); on ex_done -> FETCH, and if ex_skip=1, pc<=pc+1 modulo 2^AWIDTH.
REQ-026 HALT: halted=1; stays until reset; run ignored.
REQ-027 ex_done outside EXECUTE SHALL be ignored.
REQ-028 pc wrap: pc=2^AWIDTH-1 increments to 0 with no error.

Reset
REQ-029 On reset_n=0, immediately: state=IDLE, pc=RESET_PC, ir=0, ex_ea=0, ex_reg=0, ex_op=0, mem_req=0, ex_start=0, busy=0, halted=0.
REQ-030 Reset asserted mid-access or mid-execute SHALL abort with no further req/start; after release, the block waits in IDLE for run.

Verification
REQ-031 Direct load: pc=0x000, M[0]=0x2123, ack after 2 wait cycles -> mem_req held 3 cycles at addr 0x000, DECODE, ex_start with ex_op=2, ex_ea=0x123, pc=0x001.
REQ-032 Indirect add: M[0]=0x9050, M[0x050]=0x0ABC, zero-wait acks -> second req at 0x050, ex_op=1, ex_ea=0xABC.
REQ-033 Branch: M[0]=0x4200 -> no ex_start, next fetch addr 0x200; indirect M[0]=0xC010, M[0x010]=0x0300 -> next fetch 0x300.
REQ-034 Skip: ISZ (0x6040) with ex_done and ex_skip=1 -> next fetch at pc+2 (0x002 from 0x000); pc=0xFFF fetch wraps to 0x000.
REQ-035 Halt: M[0]=0x7001 -> halted=1, busy=0, no ex_start, run toggling has no effect; M[0]=0xF000 -> halted=1.
REQ-036 Reset asserted while mem_req=1 awaiting ack -> mem_req=0 same cycle, pc=RESET_PC, late ack ignored.
